// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: basic RV32I types, ALU codes, opcodes
// and the execute-stage pipe register payload.
package decode_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = $clog2(NUM_REGS);

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_code_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    reg_addr_t       rd;
    logic            rd_we;
    alu_code_e       alu_op;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            bp_taken;
    logic            illegal;
  } ex_pipe_reg_t;

endpackage

// File: rtl/decode_stage_if.sv
// Execute-stage pipe register bus driven by decode, consumed by execute.
interface decode_stage_if;
  import decode_stage_pkg::*;

  ex_pipe_reg_t ex;

  modport master (output ex);
  modport slave  (input  ex);
endinterface

// File: rtl/decode_stage_register_file.sv
// 32x32 architectural register file: two combinational read ports with
// write-back bypass, one write port, x0 hard-wired to zero.
module decode_stage_register_file
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  reg_addr_t       raddr1,
  input  reg_addr_t       raddr2,
  output logic [XLEN-1:0] rdata1_c,
  output logic [XLEN-1:0] rdata2_c,
  input  logic            we,
  input  reg_addr_t       waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Storage update; writes to x0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[REG_AW'(i)] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports with same-cycle write-back bypass
  always_comb begin
    rdata1_c = regs[raddr1];
    rdata2_c = regs[raddr2];
    if (raddr1 == '0)                    rdata1_c = '0;
    else if (we && (waddr == raddr1))    rdata1_c = wdata;
    if (raddr2 == '0)                    rdata2_c = '0;
    else if (we && (waddr == raddr2))    rdata2_c = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: field decode, immediate generation, operand read with
// bypass, load-use stall request and execute pipe register.
// Optional build macro: ILLEGAL_INST_DETECT_EN (illegal instructions flow on
// as ex_illegal instead of being squashed into bubbles).
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            in_bp_taken,
  input  logic            flush,
  input  logic            wb_en,
  input  reg_addr_t       wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            data_hazard,
  decode_stage_if.master  ex_bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  reg_addr_t       rs1, rs2, rd;
  logic [XLEN-1:0] rdata1_c, rdata2_c;

  logic            uses_rs1, uses_rs2, writes_rd, known, funct_bad, illegal;
  logic            is_load, is_store, is_branch, is_jump;
  alu_code_e       alu_op;
  logic [XLEN-1:0] imm;
  ex_pipe_reg_t    ex_d, ex_q;

  assign opcode = in_inst[6:0];
  assign rd     = in_inst[11:7];
  assign funct3 = in_inst[14:12];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];
  assign funct7 = in_inst[31:25];

  decode_stage_register_file u_rf (
    .clk      (clk),
    .rst_n    (rst),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (rdata1_c),
    .rdata2_c (rdata2_c),
    .we       (wb_en),
    .waddr    (wb_rd),
    .wdata    (wb_data)
  );

  // Instruction class, operand usage, immediate and ALU code by opcode
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    known     = 1'b1;
    funct_bad = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    alu_op    = ALU_ADD;
    imm       = '0;
    case (opcode)
      OP_LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
        imm       = {{20{in_inst[31]}}, in_inst[31:20]};
        funct_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_store  = 1'b1;
        imm       = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        funct_bad = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OP_BRANCH: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_branch = 1'b1;
        imm       = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
        funct_bad = (funct3[2:1] == 2'b01);
      end
      OP_JAL: begin
        writes_rd = 1'b1;
        is_jump   = 1'b1;
        imm       = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_jump   = 1'b1;
        imm       = {{20{in_inst[31]}}, in_inst[31:20]};
        funct_bad = (funct3 != 3'b000);
      end
      OP_IMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        imm       = {{20{in_inst[31]}}, in_inst[31:20]};
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
        funct_bad = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                    ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
                     (funct7 != 7'b0100000));
      end
      OP_REG: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
        case (funct3)
          3'b000:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
        funct_bad = !((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) &&
                       ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OP_LUI: begin
        writes_rd = 1'b1;
        imm       = {in_inst[31:12], 12'h000};
      end
      OP_AUIPC: begin
        writes_rd = 1'b1;
        imm       = {in_inst[31:12], 12'h000};
      end
      default: known = 1'b0;
    endcase
    illegal = !known || funct_bad;
  end

  // Load-use stall: the load in execute targets a register this instruction reads
  assign data_hazard = !flush && ex_q.valid && ex_q.is_load && (ex_q.rd != '0) &&
                       (in_inst != 32'h0) &&
                       ((uses_rs1 && (rs1 == ex_q.rd)) || (uses_rs2 && (rs2 == ex_q.rd)));

  // Next execute pipe register; flush, stall and bubbles all load zeros
  always_comb begin
    ex_d = '0;
    if (!flush && !data_hazard && (in_inst != 32'h0)) begin
      if (illegal) begin
`ifdef ILLEGAL_INST_DETECT_EN
        ex_d.valid   = 1'b1;
        ex_d.illegal = 1'b1;
        ex_d.pc      = in_pc;
`endif
      end else begin
        ex_d.valid     = 1'b1;
        ex_d.pc        = in_pc;
        ex_d.rs1_data  = uses_rs1 ? rdata1_c : '0;
        ex_d.rs2_data  = uses_rs2 ? rdata2_c : '0;
        ex_d.imm       = imm;
        ex_d.rd        = writes_rd ? rd : '0;
        ex_d.rd_we     = writes_rd && (rd != '0);
        ex_d.alu_op    = alu_op;
        ex_d.is_load   = is_load;
        ex_d.is_store  = is_store;
        ex_d.is_branch = is_branch;
        ex_d.is_jump   = is_jump;
        ex_d.bp_taken  = in_bp_taken;
      end
    end
  end

  // Execute pipe register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign ex_bus.ex = ex_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with hand-computed RV32I encodings.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_pc, in_inst, wb_data;
  logic        in_bp_taken, flush, wb_en;
  reg_addr_t   wb_rd;
  logic        data_hazard;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  decode_stage_if ex_bus ();

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .in_bp_taken (in_bp_taken),
    .flush       (flush),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .data_hazard (data_hazard),
    .ex_bus      (ex_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_pc = '0; in_inst = '0; in_bp_taken = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    tick(); tick();
    check("rst_valid",  32'(ex_bus.ex.valid), 32'd0);
    check("rst_pc",     ex_bus.ex.pc, 32'd0);
    check("rst_hazard", 32'(data_hazard), 32'd0);
    rst = 1'b1;

    // x5 = 7, then add x8,x5,x0 reads it
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'd7;
    tick();
    wb_en = 1'b0; in_pc = 32'h40; in_inst = 32'h00028433;
    tick();
    check("x5_rs1",   ex_bus.ex.rs1_data, 32'd7);
    check("x5_pc",    ex_bus.ex.pc, 32'h40);
    check("x5_rd",    32'(ex_bus.ex.rd), 32'd8);
    check("x5_rd_we", 32'(ex_bus.ex.rd_we), 32'd1);

    // asynchronous reset mid-run
    #2; rst = 1'b0; #1;
    check("mrst_valid", 32'(ex_bus.ex.valid), 32'd0);
    check("mrst_rs1",   ex_bus.ex.rs1_data, 32'd0);
    check("mrst_pc",    ex_bus.ex.pc, 32'd0);
    rst = 1'b1;
    tick();
    check("mrst_x5_cleared", ex_bus.ex.rs1_data, 32'd0);
    check("mrst_valid_back", 32'(ex_bus.ex.valid), 32'd1);

    // addi x1,x0,-5
    in_pc = 32'h100; in_inst = 32'hFFB00093;
    tick();
    check("addi_imm",   ex_bus.ex.imm, 32'hFFFFFFFB);
    check("addi_alu",   32'(ex_bus.ex.alu_op), 32'd0);
    check("addi_rd",    32'(ex_bus.ex.rd), 32'd1);
    check("addi_rd_we", 32'(ex_bus.ex.rd_we), 32'd1);

    // beq x1,x2,-8 with predicted-taken
    in_pc = 32'h104; in_inst = 32'hFE208CE3; in_bp_taken = 1'b1;
    tick();
    check("beq_imm",    ex_bus.ex.imm, 32'hFFFFFFF8);
    check("beq_branch", 32'(ex_bus.ex.is_branch), 32'd1);
    check("beq_rd_we",  32'(ex_bus.ex.rd_we), 32'd0);
    check("beq_bp",     32'(ex_bus.ex.bp_taken), 32'd1);
    in_bp_taken = 1'b0;

    // bypass: write x3 while decoding add x4,x3,x0
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234; in_inst = 32'h00018233;
    tick();
    check("byp_rs1", ex_bus.ex.rs1_data, 32'h1234);
    check("byp_rd",  32'(ex_bus.ex.rd), 32'd4);
    wb_en = 1'b0;
    tick();
    check("byp_commit", ex_bus.ex.rs1_data, 32'h1234);

    // writes to x0 are ignored, even on the bypass path
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF; in_inst = 32'h00000233;
    tick();
    check("x0_byp", ex_bus.ex.rs1_data, 32'd0);
    wb_en = 1'b0;
    tick();
    check("x0_read", ex_bus.ex.rs1_data, 32'd0);

    // sub x9,x3,x3
    in_inst = 32'h403184B3;
    tick();
    check("sub_alu", 32'(ex_bus.ex.alu_op), 32'd1);
    check("sub_rs2", ex_bus.ex.rs2_data, 32'h1234);

    // srai x10,x3,4
    in_inst = 32'h4041D513;
    tick();
    check("srai_alu", 32'(ex_bus.ex.alu_op), 32'd7);
    check("srai_imm", ex_bus.ex.imm, 32'h00000404);

    // lui x11,0x12345
    in_inst = 32'h123455B7;
    tick();
    check("lui_imm", ex_bus.ex.imm, 32'h12345000);
    check("lui_rd",  32'(ex_bus.ex.rd), 32'd11);

    // jal x1,+16
    in_inst = 32'h010000EF;
    tick();
    check("jal_imm",  ex_bus.ex.imm, 32'd16);
    check("jal_jump", 32'(ex_bus.ex.is_jump), 32'd1);

    // sw x3,-4(x1)
    in_inst = 32'hFE30AE23;
    tick();
    check("sw_imm",   ex_bus.ex.imm, 32'hFFFFFFFC);
    check("sw_store", 32'(ex_bus.ex.is_store), 32'd1);
    check("sw_rd_we", 32'(ex_bus.ex.rd_we), 32'd0);
    check("sw_rs2",   ex_bus.ex.rs2_data, 32'h1234);

    // bubble input
    in_pc = 32'h200; in_inst = 32'h0;
    tick();
    check("bub_valid", 32'(ex_bus.ex.valid), 32'd0);
    check("bub_pc",    ex_bus.ex.pc, 32'd0);

    // unknown opcode
    in_inst = 32'hFFFFFFFF;
    tick();
`ifdef ILLEGAL_INST_DETECT_EN
    check("ill_valid", 32'(ex_bus.ex.valid), 32'd1);
    check("ill_flag",  32'(ex_bus.ex.illegal), 32'd1);
    check("ill_rd_we", 32'(ex_bus.ex.rd_we), 32'd0);
`else
    check("ill_valid", 32'(ex_bus.ex.valid), 32'd0);
    check("ill_flag",  32'(ex_bus.ex.illegal), 32'd0);
`endif

    // load-use: lw x6,0(x1) then add x7,x6,x6
    in_inst = 32'h0000A303;
    tick();
    check("lw_load", 32'(ex_bus.ex.is_load), 32'd1);
    check("lw_rd",   32'(ex_bus.ex.rd), 32'd6);
    in_inst = 32'h00608393;
    #1;
    check("lu_irs2_nohaz", 32'(data_hazard), 32'd0);
    in_inst = 32'h006303B3;
    #1;
    check("lu_hazard", 32'(data_hazard), 32'd1);
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'hCAFE;
    tick();
    check("lu_bub_valid", 32'(ex_bus.ex.valid), 32'd0);
    check("lu_bub_load",  32'(ex_bus.ex.is_load), 32'd0);
    check("lu_haz_clear", 32'(data_hazard), 32'd0);
    wb_en = 1'b0;
    tick();
    check("lu_valid", 32'(ex_bus.ex.valid), 32'd1);
    check("lu_rs1",   ex_bus.ex.rs1_data, 32'hCAFE);
    check("lu_rs2",   ex_bus.ex.rs2_data, 32'hCAFE);
    check("lu_rd",    32'(ex_bus.ex.rd), 32'd7);

    // flush beats a pending load-use stall
    in_inst = 32'h0000A303;
    tick();
    in_inst = 32'h006303B3;
    #1;
    check("fl_pre_hazard", 32'(data_hazard), 32'd1);
    flush = 1'b1;
    #1;
    check("fl_hazard", 32'(data_hazard), 32'd0);
    tick();
    check("fl_valid", 32'(ex_bus.ex.valid), 32'd0);
    check("fl_load",  32'(ex_bus.ex.is_load), 32'd0);
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
